// File: rtl/hazard_ctrl.sv
// Stall and forwarding control for the 5-stage pipeline, driven by shadow copies of E/M/W
// destinations. Defining MDU_STALL_EN adds a mult/div busy counter that stalls MDU users in D.
module hazard_ctrl #(
  parameter int unsigned TNEW_W      = 2,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        D_rs,
  input  logic [4:0]        D_rt,
  input  logic [TNEW_W-1:0] D_Tuse_rs,
  input  logic [TNEW_W-1:0] D_Tuse_rt,
  input  logic [4:0]        D_A3,
  input  logic [TNEW_W-1:0] D_Tnew,
  input  logic              D_md,
  input  logic              E_md_start,
  input  logic              E_md_isdiv,
  output logic              stall,
  output logic [1:0]        FwdCMPD1,
  output logic [1:0]        FwdCMPD2,
  output logic [1:0]        FwdALUA,
  output logic [1:0]        FwdALUB,
  output logic              FwdDM
);

  typedef logic [TNEW_W-1:0] tnew_t;

  // Shadow pipeline state: only what the hazard rules need.
  logic [4:0] e_a3_q, e_a3_d;
  tnew_t      e_tnew_q, e_tnew_d;
  logic [4:0] e_rs_q, e_rs_d;
  logic [4:0] e_rt_q, e_rt_d;
  logic [4:0] m_a3_q, m_a3_d;
  tnew_t      m_tnew_q, m_tnew_d;
  logic [4:0] m_rt_q, m_rt_d;
  logic [4:0] w_a3_q, w_a3_d;

  logic rs_stall, rt_stall, md_stall;

  // A source stalls when a producer in E or M will not have its value by the time it is used.
  function automatic logic src_stall(input logic [4:0] src, input tnew_t tuse,
                                     input logic [4:0] ea3, input tnew_t etnew,
                                     input logic [4:0] ma3, input tnew_t mtnew);
    logic hit_e, hit_m;
    hit_e = (ea3 == src) && (etnew > tuse);
    hit_m = (ma3 == src) && (mtnew > tuse);
    return (src != 5'd0) && (hit_e || hit_m);
  endfunction

  // D-stage compare/jr operand: E result has priority over M result.
  function automatic logic [1:0] fwd_d(input logic [4:0] src,
                                      input logic [4:0] ea3, input tnew_t etnew,
                                      input logic [4:0] ma3, input tnew_t mtnew);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      if ((ea3 == src) && (etnew == '0)) begin
        sel = 2'b10;
      end else if ((ma3 == src) && (mtnew == '0)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // E-stage ALU operand: M result has priority over W result.
  function automatic logic [1:0] fwd_e(input logic [4:0] src,
                                      input logic [4:0] ma3, input tnew_t mtnew,
                                      input logic [4:0] wa3);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      if ((ma3 == src) && (mtnew == '0)) begin
        sel = 2'b10;
      end else if (wa3 == src) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

`ifdef MDU_STALL_EN
  logic [3:0] busy_q, busy_d;

  // A new op only loads while idle; the count then runs down regardless of stalls.
  always_comb begin
    busy_d = busy_q;
    if (E_md_start && (busy_q == 4'd0)) begin
      busy_d = E_md_isdiv ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (busy_q != 4'd0) begin
      busy_d = busy_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 4'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign md_stall = D_md && (E_md_start || (busy_q != 4'd0));
`else
  logic unused_md;

  assign md_stall  = 1'b0;
  assign unused_md = ^{D_md, E_md_start, E_md_isdiv, 4'(MULT_CYCLES), 4'(DIV_CYCLES)};
`endif

  always_comb begin
    rs_stall = src_stall(D_rs, D_Tuse_rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
    rt_stall = src_stall(D_rt, D_Tuse_rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
    stall    = rs_stall || rt_stall || md_stall;
    FwdCMPD1 = fwd_d(D_rs, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
    FwdCMPD2 = fwd_d(D_rt, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q);
    FwdALUA  = fwd_e(e_rs_q, m_a3_q, m_tnew_q, w_a3_q);
    FwdALUB  = fwd_e(e_rt_q, m_a3_q, m_tnew_q, w_a3_q);
    FwdDM    = (m_rt_q != 5'd0) && (w_a3_q == m_rt_q);
  end

  always_comb begin
    if (stall) begin
      // Bubble into E: an A3 of zero makes the slot inert.
      e_a3_d   = 5'd0;
      e_tnew_d = '0;
      e_rs_d   = 5'd0;
      e_rt_d   = 5'd0;
    end else begin
      e_a3_d   = D_A3;
      e_tnew_d = D_Tnew;
      e_rs_d   = D_rs;
      e_rt_d   = D_rt;
    end
    m_a3_d   = e_a3_q;
    m_rt_d   = e_rt_q;
    m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - tnew_t'(1);
    w_a3_d   = m_a3_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_a3_q   <= 5'd0;
      e_tnew_q <= '0;
      e_rs_q   <= 5'd0;
      e_rt_q   <= 5'd0;
      m_a3_q   <= 5'd0;
      m_tnew_q <= '0;
      m_rt_q   <= 5'd0;
      w_a3_q   <= 5'd0;
    end else begin
      e_a3_q   <= e_a3_d;
      e_tnew_q <= e_tnew_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      m_a3_q   <= m_a3_d;
      m_tnew_q <= m_tnew_d;
      m_rt_q   <= m_rt_d;
      w_a3_q   <= w_a3_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus randomized instruction streams
// checked against an instruction-level pipeline model.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_A3;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
  logic       D_md, E_md_start, E_md_isdiv;
  logic       stall;
  logic [1:0] FwdCMPD1, FwdCMPD2, FwdALUA, FwdALUB;
  logic       FwdDM;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_Tuse_rs  (D_Tuse_rs),
    .D_Tuse_rt  (D_Tuse_rt),
    .D_A3       (D_A3),
    .D_Tnew     (D_Tnew),
    .D_md       (D_md),
    .E_md_start (E_md_start),
    .E_md_isdiv (E_md_isdiv),
    .stall      (stall),
    .FwdCMPD1   (FwdCMPD1),
    .FwdCMPD2   (FwdCMPD2),
    .FwdALUA    (FwdALUA),
    .FwdALUB    (FwdALUB),
    .FwdDM      (FwdDM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: instructions in flight, index 0=E, 1=M, 2=W, each keeping its entry Tnew.
  typedef struct {
    logic [4:0] a3;
    logic [4:0] rs;
    logic [4:0] rt;
    int         tnew;
  } instr_t;

  instr_t pipe [3];
  int     md_busy;

  // Cycles still needed by the instruction in a stage; stage index equals cycles since entering E.
  function automatic int ready_in(input int st);
    int r;
    if (st == 2) return 0;
    r = pipe[st].tnew - st;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic logic m_src_stall(input logic [4:0] s, input int tuse);
    if (s == 5'd0) return 1'b0;
    for (int st = 0; st < 2; st++) begin
      if (pipe[st].a3 == s && ready_in(st) > tuse) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic m_stall();
    logic md;
    md = 1'b0;
`ifdef MDU_STALL_EN
    md = D_md && (E_md_start || md_busy > 0);
`endif
    return m_src_stall(D_rs, int'(D_Tuse_rs)) || m_src_stall(D_rt, int'(D_Tuse_rt)) || md;
  endfunction

  function automatic logic [1:0] m_fwd_d(input logic [4:0] s);
    if (s == 5'd0) return 2'b00;
    for (int st = 0; st < 2; st++) begin
      if (pipe[st].a3 == s && ready_in(st) == 0) return (st == 0) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic [1:0] m_fwd_e(input logic [4:0] s);
    if (s == 5'd0) return 2'b00;
    for (int st = 1; st < 3; st++) begin
      if (pipe[st].a3 == s && ready_in(st) == 0) return (st == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic logic m_fwd_dm();
    return (pipe[1].rt != 5'd0) && (pipe[2].a3 == pipe[1].rt);
  endfunction

  task automatic model_advance(input logic st);
    if (reset) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{a3: 5'd0, rs: 5'd0, rt: 5'd0, tnew: 0};
      md_busy = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (st) pipe[0] = '{a3: 5'd0, rs: 5'd0, rt: 5'd0, tnew: 0};
      else    pipe[0] = '{a3: D_A3, rs: D_rs, rt: D_rt, tnew: int'(D_Tnew)};
      if (E_md_start && md_busy == 0) md_busy = E_md_isdiv ? 10 : 5;
      else if (md_busy > 0) md_busy--;
    end
  endtask

  task automatic tick();
    logic st;
    st = m_stall();
    @(posedge clk);
    model_advance(st);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tuse_rs,
                       input logic [1:0] tuse_rt, input logic [4:0] a3, input logic [1:0] tnew);
    D_rs = rs; D_rt = rt; D_Tuse_rs = tuse_rs; D_Tuse_rt = tuse_rt; D_A3 = a3; D_Tnew = tnew;
    #1;
  endtask

  task automatic do_reset();
    set_d(0, 0, 0, 0, 0, 0);
    D_md = 1'b0; E_md_start = 1'b0; E_md_isdiv = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    set_d(0, 0, 0, 0, 0, 0);
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_tests++; if (FwdCMPD1 !== 2'b00) begin n_fail++; $display("FAIL reset_cmpd1: got %b want 00", FwdCMPD1); end
    n_tests++; if (FwdCMPD2 !== 2'b00) begin n_fail++; $display("FAIL reset_cmpd2: got %b want 00", FwdCMPD2); end
    n_tests++; if (FwdALUA !== 2'b00) begin n_fail++; $display("FAIL reset_alua: got %b want 00", FwdALUA); end
    n_tests++; if (FwdALUB !== 2'b00) begin n_fail++; $display("FAIL reset_alub: got %b want 00", FwdALUB); end
    n_tests++; if (FwdDM !== 1'b0) begin n_fail++; $display("FAIL reset_dm: got %b want 0", FwdDM); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(0, 0, 0, 0, 5'd1, 2'd2);               // lw $1
    tick();
    set_d(5'd1, 0, 2'd1, 2'd1, 5'd5, 2'd1);      // addu $5, $1
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall: got %b want 1", stall); end
    tick();
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release: got %b want 0", stall); end
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    n_tests++; if (FwdALUA !== 2'b01) begin n_fail++; $display("FAIL load_use_alua: got %b want 01", FwdALUA); end
  endtask

  task automatic test_branch();
    do_reset();
    set_d(0, 0, 0, 0, 5'd2, 2'd1);               // addu $2
    tick();
    set_d(5'd2, 0, 2'd0, 2'd0, 0, 0);            // beq $2
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL branch_stall: got %b want 1", stall); end
    tick();
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL branch_release: got %b want 0", stall); end
    n_tests++; if (FwdCMPD1 !== 2'b01) begin n_fail++; $display("FAIL branch_cmpd1: got %b want 01", FwdCMPD1); end
  endtask

  task automatic test_jal_jr();
    do_reset();
    set_d(0, 0, 0, 0, 5'd31, 2'd0);              // jal
    tick();
    set_d(5'd31, 0, 2'd0, 2'd0, 0, 0);           // jr $31
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL jr_stall: got %b want 0", stall); end
    n_tests++; if (FwdCMPD1 !== 2'b10) begin n_fail++; $display("FAIL jr_cmpd1: got %b want 10", FwdCMPD1); end
    n_tests++; if (FwdCMPD2 !== 2'b00) begin n_fail++; $display("FAIL jr_cmpd2: got %b want 00", FwdCMPD2); end
  endtask

  task automatic test_load_store();
    do_reset();
    set_d(0, 0, 0, 0, 5'd3, 2'd2);               // lw $3
    tick();
    set_d(0, 5'd3, 2'd1, 2'd2, 0, 0);            // sw $3
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL store_stall: got %b want 0", stall); end
    n_tests++; if (FwdCMPD2 !== 2'b00) begin n_fail++; $display("FAIL store_cmpd2: got %b want 00", FwdCMPD2); end
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    n_tests++; if (FwdALUB !== 2'b00) begin n_fail++; $display("FAIL store_alub: got %b want 00", FwdALUB); end
    tick();
    n_tests++; if (FwdDM !== 1'b1) begin n_fail++; $display("FAIL store_dm: got %b want 1", FwdDM); end
  endtask

  task automatic test_mdu();
    do_reset();
`ifdef MDU_STALL_EN
    D_md = 1'b1; E_md_start = 1'b1; E_md_isdiv = 1'b1;   // div in E, mflo in D
    #1;
    for (int c = 0; c < 11; c++) begin
      n_tests++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL mdu_div_busy c%0d: got %b want 1", c, stall); end
      tick();
      E_md_start = 1'b0;
    end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mdu_div_done: got %b want 0", stall); end
    E_md_start = 1'b1; E_md_isdiv = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      tick();
      E_md_start = 1'b0;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mdu_reset: got %b want 0", stall); end
`else
    D_md = 1'b1; E_md_start = 1'b1; E_md_isdiv = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mdu_ignored: got %b want 0", stall); end
    tick();
    E_md_start = 1'b0;
    #1;
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mdu_ignored_next: got %b want 0", stall); end
`endif
    D_md = 1'b0; E_md_start = 1'b0;
  endtask

  task automatic test_random();
    logic       e_st, e_dm;
    logic [1:0] e_c1, e_c2, e_a, e_b;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      D_md       = ($urandom_range(0, 7) == 0);
      E_md_start = ($urandom_range(0, 15) == 0);
      E_md_isdiv = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 63) == 0);
      set_d(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
            2'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
      e_st = m_stall();
      e_c1 = m_fwd_d(D_rs);
      e_c2 = m_fwd_d(D_rt);
      e_a  = m_fwd_e(pipe[0].rs);
      e_b  = m_fwd_e(pipe[0].rt);
      e_dm = m_fwd_dm();
      n_tests++; if (stall !== e_st) begin n_fail++; $display("FAIL rnd_stall @%0d: got %b want %b", i, stall, e_st); end
      n_tests++; if (FwdCMPD1 !== e_c1) begin n_fail++; $display("FAIL rnd_cmpd1 @%0d: got %b want %b", i, FwdCMPD1, e_c1); end
      n_tests++; if (FwdCMPD2 !== e_c2) begin n_fail++; $display("FAIL rnd_cmpd2 @%0d: got %b want %b", i, FwdCMPD2, e_c2); end
      n_tests++; if (FwdALUA !== e_a) begin n_fail++; $display("FAIL rnd_alua @%0d: got %b want %b", i, FwdALUA, e_a); end
      n_tests++; if (FwdALUB !== e_b) begin n_fail++; $display("FAIL rnd_alub @%0d: got %b want %b", i, FwdALUB, e_b); end
      n_tests++; if (FwdDM !== e_dm) begin n_fail++; $display("FAIL rnd_dm @%0d: got %b want %b", i, FwdDM, e_dm); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    D_md = 1'b0; E_md_start = 1'b0; E_md_isdiv = 1'b0;
    D_rs = 0; D_rt = 0; D_Tuse_rs = 0; D_Tuse_rt = 0; D_A3 = 0; D_Tnew = 0;
    for (int i = 0; i < 3; i++) pipe[i] = '{a3: 5'd0, rs: 5'd0, rt: 5'd0, tnew: 0};
    md_busy = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_jal_jr();
    test_load_store();
    test_mdu();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
